test_seq_ctrl: RTL and testbench

- Test-sequence controller for the FPGA tester. It sits downstream of the key driver and takes its stretched switch/reset key levels.
- Switch key presses select the test mode. A reset key press runs one test: the DUT reset phase, a start pulse, then a wait for completion with a timeout.
- It holds the pass/fail/timeout result for the status LEDs and display logic.

---
 rtl/tester_pkg.sv | 26 ++
 rtl/key_press_det.sv | 46 ++++
 rtl/test_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_test_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tester_pkg.sv
// Shared types and helpers for the FPGA tester sequence controller.
package tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_t;

    // Largest of three counts, used to size the shared cycle counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_press_det.sv
// Rising-edge detector on a stretched key level with a per-key hold-off window.
module key_press_det #(
    parameter int unsigned HOLDOFF = 1000
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_key,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(HOLDOFF + 1);

    logic             key_q, key_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_c;

    // Edge detect, accept only when the hold-off window has expired.
    always_comb begin
        key_d   = in_key;
        edge_c  = in_key & ~key_q;
        press_d = edge_c && (cnt_q == '0);
        cnt_d   = cnt_q;
        if (press_d) begin
            cnt_d = CNT_W'(HOLDOFF - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // History resets high so a key held through reset release is not a press.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            key_q   <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            key_q   <= key_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/test_seq_ctrl.sv
// Test-sequence controller: mode select, DUT reset/start, completion wait with timeout.
module test_seq_ctrl
    import tester_pkg::*;
#(
    parameter int unsigned N_MODES = 4,
    parameter int unsigned MODE_W  = $clog2(N_MODES),
    parameter int unsigned HOLDOFF = 1000,
    parameter int unsigned RST_CYC = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_key_switch,
    input  logic              in_key_reset,
    input  logic              in_test_done,
    input  logic              in_test_pass,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_test_rst,
    output logic              o_test_start,
    output logic              o_busy,
    output logic [1:0]        o_result
);

    localparam int unsigned CNT_MAX = max3(TIMEOUT, RST_CYC, HOLDOFF);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic sw_press;
    logic rst_press;

    key_press_det #(.HOLDOFF(HOLDOFF)) u_det_switch (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_key (in_key_switch),
        .o_press(sw_press)
    );

    key_press_det #(.HOLDOFF(HOLDOFF)) u_det_reset (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_key (in_key_reset),
        .o_press(rst_press)
    );

    seq_state_t        state_q, state_d;
    result_t           result_q, result_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              test_rst_q, test_rst_d;
    logic              test_start_q, test_start_d;
    logic              busy_q, busy_d;

    // Next-state and next-output logic; reset press has priority over switch press.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        test_rst_d   = 1'b0;
        test_start_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (rst_press) begin
                    state_d    = RST;
                    result_d   = RES_NONE;
                    cnt_d      = '0;
                    test_rst_d = 1'b1;
                end else if (sw_press) begin
                    mode_d   = (mode_q == MODE_W'(N_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
                    result_d = RES_NONE;
                    state_d  = IDLE;
                end
            end
            RST: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d      = RUN;
                    test_start_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    test_rst_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (rst_press) begin
                    state_d    = IDLE;
                    result_d   = RES_NONE;
                    test_rst_d = 1'b1;
                end else if (in_test_done) begin
                    state_d  = DONE;
                    result_d = in_test_pass ? RES_PASS : RES_FAIL;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    result_d = RES_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RST) || (state_d == RUN);
    end

    // State and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= IDLE;
            result_q     <= RES_NONE;
            mode_q       <= '0;
            cnt_q        <= '0;
            test_rst_q   <= 1'b0;
            test_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            test_rst_q   <= test_rst_d;
            test_start_q <= test_start_d;
            busy_q       <= busy_d;
        end
    end

    assign o_mode       = mode_q;
    assign o_test_rst   = test_rst_q;
    assign o_test_start = test_start_q;
    assign o_busy       = busy_q;
    assign o_result     = result_q;

endmodule

// File: tb/tb_test_seq_ctrl.sv
// Directed bench for test_seq_ctrl (N_MODES=4, HOLDOFF=4, RST_CYC=3, TIMEOUT=20).
module tb_test_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       rk;
    logic       done;
    logic       pass;
    logic [1:0] mode;
    logic       trst;
    logic       start;
    logic       busy;
    logic [1:0] result;

    int total;
    int bad;
    int exp_mode;

    typedef struct {
        logic sw;
        logic rk;
        logic dn;
        logic ps;
        int   res;
        int   trst;
        int   st;
        int   busy;
    } row_t;

    row_t tbl[$];

    test_seq_ctrl #(
        .N_MODES(4),
        .MODE_W (2),
        .HOLDOFF(4),
        .RST_CYC(3),
        .TIMEOUT(20)
    ) dut (
        .in_clk       (clk),
        .in_rst       (rst_n),
        .in_key_switch(sw),
        .in_key_reset (rk),
        .in_test_done (done),
        .in_test_pass (pass),
        .o_mode       (mode),
        .o_test_rst   (trst),
        .o_test_start (start),
        .o_busy       (busy),
        .o_result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int res, input int tr,
                           input int st, input int bz);
        chk({tag, ".mode"}, int'(mode), m);
        chk({tag, ".result"}, int'(result), res);
        chk({tag, ".test_rst"}, int'(trst), tr);
        chk({tag, ".test_start"}, int'(start), st);
        chk({tag, ".busy"}, int'(busy), bz);
    endtask

    task automatic add(input logic s, input logic r, input logic d, input logic p,
                       input int res, input int tr, input int st, input int bz);
        row_t x;
        x.sw = s; x.rk = r; x.dn = d; x.ps = p;
        x.res = res; x.trst = tr; x.st = st; x.busy = bz;
        tbl.push_back(x);
    endtask

    // Reset press (optionally with a simultaneous switch press) up to the first RUN cycle.
    task automatic enter_run(input logic with_sw);
        done = 1'b0;
        sw = with_sw; rk = 1'b1; step();
        chk("enter.pending_trst", int'(trst), 0);
        chk("enter.pending_busy", int'(busy), 0);
        step();
        chk_all("enter.rst1", exp_mode, 0, 1, 0, 1);
        sw = 1'b0; rk = 1'b0; step();
        chk("enter.rst2", int'(trst), 1);
        step();
        chk("enter.rst3", int'(trst), 1);
        step();
        chk_all("enter.run1", exp_mode, 0, 0, 1, 1);
    endtask

    // Full test from IDLE/DONE; done_cyc=0 means the DUT never reports done.
    task automatic run_test(input int done_cyc, input logic p, input int exp_res);
        enter_run(1'b0);
        for (int c = 1; c <= 20; c++) begin
            done = (c == done_cyc); pass = p;
            step();
            if (c == done_cyc || c == 20) begin
                chk_all($sformatf("run.end%0d", c), exp_mode, exp_res, 0, 0, 0);
                break;
            end else begin
                chk($sformatf("run.busy%0d", c), int'(busy), 1);
                chk($sformatf("run.res%0d", c), int'(result), 0);
                chk($sformatf("run.start%0d", c), int'(start), 0);
            end
        end
        done = 1'b0; pass = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; exp_mode = 0;
        rst_n = 1'b0; sw = 1'b1; rk = 1'b0; done = 1'b0; pass = 1'b0;

        // Reset values with the switch key held through reset.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_key_no_press", int'(mode), 0);
        end

        // Fresh edge: mode advances two cycles after it.
        sw = 1'b0; step();
        sw = 1'b1; step();
        chk("edge.cycle1", int'(mode), 0);
        sw = 1'b0; step();
        exp_mode = 1;
        chk("edge.cycle2", int'(mode), exp_mode);
        idle(8);

        // Five well-spaced presses, wrapping at N_MODES.
        for (int i = 0; i < 5; i++) begin
            sw = 1'b1; step();
            sw = 1'b0; step();
            exp_mode = (exp_mode + 1) % 4;
            chk($sformatf("step%0d", i), int'(mode), exp_mode);
            chk($sformatf("step%0d.result", i), int'(result), 0);
            idle(8);
        end

        // Second edge inside the hold-off window is ignored.
        sw = 1'b1; step();
        sw = 1'b0; step();
        exp_mode = (exp_mode + 1) % 4;
        chk("holdoff.accepted", int'(mode), exp_mode);
        sw = 1'b1; step();
        sw = 1'b0; step();
        step();
        chk("holdoff.rejected", int'(mode), exp_mode);
        idle(8);

        // Done strobe outside RUN has no effect.
        done = 1'b1; pass = 1'b1; step();
        done = 1'b0; pass = 1'b0; step();
        chk_all("done_in_idle", exp_mode, 0, 0, 0, 0);

        // Table: pass test from IDLE, then fail test from DONE.
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 2, 0, 0, 0);
        add(0, 0, 1, 1, 2, 0, 0, 0);
        foreach (tbl[i]) begin
            sw = tbl[i].sw; rk = tbl[i].rk; done = tbl[i].dn; pass = tbl[i].ps;
            step();
            chk_all($sformatf("tbl%0d", i), exp_mode, tbl[i].res, tbl[i].trst,
                    tbl[i].st, tbl[i].busy);
        end
        sw = 1'b0; rk = 1'b0; done = 1'b0; pass = 1'b0;
        idle(5);

        // Timeout, then done on the last allowed cycle beats timeout.
        run_test(0, 1'b0, 3);
        idle(5);
        run_test(20, 1'b1, 1);
        idle(5);
        run_test(20, 1'b0, 2);
        idle(5);

        // Switch press during RUN ignored; reset press aborts with a 1-cycle DUT reset.
        enter_run(1'b0);
        sw = 1'b1; step();
        sw = 1'b1; step();
        sw = 1'b0; step();
        chk("run.switch_ignored", int'(mode), exp_mode);
        chk("run.still_busy", int'(busy), 1);
        rk = 1'b1; step();
        chk("abort.pending", int'(busy), 1);
        rk = 1'b0; step();
        chk_all("abort", exp_mode, 0, 1, 0, 0);
        step();
        chk_all("abort.after", exp_mode, 0, 0, 0, 0);
        idle(5);

        // Simultaneous presses in DONE: reset wins, mode unchanged.
        run_test(2, 1'b0, 2);
        idle(5);
        enter_run(1'b1);
        step();
        chk("sim.mode", int'(mode), exp_mode);
        chk("sim.busy", int'(busy), 1);

        // Asynchronous reset mid-RUN.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        exp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("async_reset.held", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk_all("after_reset", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
